// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - core configuration record consumed by the dcache TID arbiter
package config_pkg;

  typedef struct packed {
    int unsigned MEM_TID_WIDTH;
    int unsigned DCACHE_MAX_TX;
  } cva6_cfg_t;

  // Smallest useful configuration: 2-bit TIDs, four transactions in flight.
  localparam cva6_cfg_t cva6_cfg_empty = '{MEM_TID_WIDTH: 32'd2, DCACHE_MAX_TX: 32'd4};

endpackage

// File: rtl/tid_arb_pkg.sv
// rtl/tid_arb_pkg.sv - shared state type and sizing helper for the dcache TID arbiter
package tid_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned owner_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_tid_arbiter_rr.sv
// rtl/dcache_tid_arbiter_rr.sv - round-robin requester selection with its own priority pointer
module dcache_tid_arbiter_rr
  import tid_arb_pkg::*;
#(
  parameter int unsigned NrReq = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NrReq-1:0]              req_i,
  input  logic                          en_i,
  output logic [NrReq-1:0]              gnt_o,
  output logic [owner_width(NrReq)-1:0] idx_o
);

  localparam int unsigned OwnW = owner_width(NrReq);

  logic [OwnW-1:0] ptr_q;
  logic [OwnW-1:0] sel;

  function automatic logic [OwnW-1:0] wrap(input int unsigned v);
    return OwnW'(v % NrReq);
  endfunction

  // Scan from the farthest offset down so the requester nearest the pointer wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    sel   = '0;
    for (int off = NrReq - 1; off >= 0; off--) begin
      sel = wrap(int'(ptr_q) + off);
      if (req_i[sel]) begin
        gnt_o      = '0;
        gnt_o[sel] = 1'b1;
        idx_o      = sel;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= wrap(int'(idx_o) + 1);
    end
  end

endmodule

// File: rtl/lzc.sv
// rtl/lzc.sv - zero count from the LSB side, i.e. index of the lowest set bit
module lzc #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = CNT_W'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/dcache_tid_arbiter.sv
// rtl/dcache_tid_arbiter.sv - grants requesters a free memory TID and tracks it until its response
module dcache_tid_arbiter
  import tid_arb_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned           NrReq   = 3
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [NrReq-1:0]                            req_i,
  output logic [NrReq-1:0]                            gnt_o,
  output logic [CVA6Cfg.MEM_TID_WIDTH-1:0]            tid_o,
  input  logic                                        mem_ready_i,
  input  logic                                        rsp_valid_i,
  input  logic [CVA6Cfg.MEM_TID_WIDTH-1:0]            rsp_tid_i,
  output logic [owner_width(NrReq)-1:0]               rsp_owner_o,
  input  logic                                        flush_i,
  output logic                                        flush_done_o,
  output logic [$clog2(CVA6Cfg.DCACHE_MAX_TX+1)-1:0]  outstanding_o,
  output logic                                        spurious_o
);

  localparam int unsigned TidW   = CVA6Cfg.MEM_TID_WIDTH;
  localparam int unsigned NumTid = CVA6Cfg.DCACHE_MAX_TX;
  localparam int unsigned OwnW   = owner_width(NrReq);
  localparam int unsigned CntW   = $clog2(NumTid + 1);
  localparam int unsigned IdxW   = (NumTid > 1) ? $clog2(NumTid) : 1;

  arb_state_e      state_q, state_d;
  logic [NumTid-1:0] busy_q;
  logic [OwnW-1:0] owner_q [NumTid];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flush_done_q, flush_done_d;

  logic [IdxW-1:0]  free_idx;
  logic             no_free;
  logic [NrReq-1:0] rr_gnt;
  logic [OwnW-1:0]  rr_idx;
  logic             grant;
  logic             rsp_hit;

  lzc #(
    .WIDTH (NumTid),
    .CNT_W (IdxW)
  ) u_free_tid (
    .in_i    (~busy_q),
    .cnt_o   (free_idx),
    .empty_o (no_free)
  );

  dcache_tid_arbiter_rr #(
    .NrReq (NrReq)
  ) u_rr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .en_i   (grant),
    .gnt_o  (rr_gnt),
    .idx_o  (rr_idx)
  );

  // A flush in the same cycle as a request wins; outputs stay quiet while in reset.
  assign grant   = rst_ni && (state_q == IDLE) && !flush_i && mem_ready_i && (|req_i) && !no_free;
  assign rsp_hit = rsp_valid_i && busy_q[rsp_tid_i];

  assign gnt_o         = grant ? rr_gnt : '0;
  assign tid_o         = TidW'(free_idx);
  assign rsp_owner_o   = owner_q[rsp_tid_i];
  assign spurious_o    = rst_ni && rsp_valid_i && !busy_q[rsp_tid_i];
  assign outstanding_o = cnt_q;
  assign flush_done_o  = flush_done_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({grant, rsp_hit})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Drain completes on the edge that retires the last TID; the done pulse follows from a register.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          if (cnt_q == '0) flush_done_d = 1'b1;
          else             state_d      = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_d == '0) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      busy_q       <= '0;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
      for (int i = 0; i < NumTid; i++) owner_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
      if (rsp_hit) busy_q[rsp_tid_i] <= 1'b0;
      if (grant) begin
        busy_q[free_idx]  <= 1'b1;
        owner_q[free_idx] <= rr_idx;
      end
    end
  end

endmodule

// File: tb/tb_dcache_tid_arbiter.sv
// tb/tb_dcache_tid_arbiter.sv - directed vector table plus randomized run against a behavioural model
module tb_dcache_tid_arbiter;

  localparam config_pkg::cva6_cfg_t Cfg = '{MEM_TID_WIDTH: 32'd2, DCACHE_MAX_TX: 32'd4};
  localparam int NrReq  = 3;
  localparam int NumTid = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req   = '0;
  logic       rdy   = 1'b0;
  logic       rv    = 1'b0;
  logic [1:0] rtid  = '0;
  logic       fl    = 1'b0;

  logic [2:0] gnt;
  logic [1:0] tid;
  logic [1:0] owner;
  logic       fd;
  logic       spur;
  logic [2:0] outst;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dcache_tid_arbiter #(
    .CVA6Cfg (Cfg),
    .NrReq   (NrReq)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .gnt_o         (gnt),
    .tid_o         (tid),
    .mem_ready_i   (rdy),
    .rsp_valid_i   (rv),
    .rsp_tid_i     (rtid),
    .rsp_owner_o   (owner),
    .flush_i       (fl),
    .flush_done_o  (fd),
    .outstanding_o (outst),
    .spurious_o    (spur)
  );

  // Behavioural model: a set of busy TIDs with owners, a rotating priority, a draining flag.
  int m_busy [NumTid];
  int m_owner[NumTid];
  int m_ptr;
  int m_drain;
  int m_fd;

  int p_ok, p_idx, p_tid, p_gnt, p_out, p_spur, p_owner, p_fd;

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < NumTid; i++) n += m_busy[i];
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NumTid; i++) begin
      m_busy[i]  = 0;
      m_owner[i] = 0;
    end
    m_ptr   = 0;
    m_drain = 0;
    m_fd    = 0;
  endfunction

  function automatic void predict();
    int rq = int'(req);
    int rt = int'(rtid);
    p_out = busy_count();
    p_tid = -1;
    for (int i = NumTid - 1; i >= 0; i--) if (m_busy[i] == 0) p_tid = i;
    p_idx = -1;
    for (int k = NrReq - 1; k >= 0; k--) begin
      if (((rq >> ((m_ptr + k) % NrReq)) & 1) == 1) p_idx = (m_ptr + k) % NrReq;
    end
    p_ok    = (rst_n && m_drain == 0 && !fl && rdy && rq != 0 && p_tid >= 0) ? 1 : 0;
    p_gnt   = p_ok ? (1 << p_idx) : 0;
    p_spur  = (rv && m_busy[rt] == 0) ? 1 : 0;
    p_owner = m_owner[rt];
    p_fd    = m_fd;
  endfunction

  function automatic void model_update();
    int rt  = int'(rtid);
    int pre = busy_count();
    if (rv && m_busy[rt] == 1) m_busy[rt] = 0;
    if (p_ok == 1) begin
      m_busy[p_tid]  = 1;
      m_owner[p_tid] = p_idx;
      m_ptr          = (p_idx + 1) % NrReq;
    end
    m_fd = 0;
    if (m_drain == 0) begin
      if (fl) begin
        if (pre == 0) m_fd = 1;
        else          m_drain = 1;
      end
    end else if (busy_count() == 0) begin
      m_drain = 0;
      m_fd    = 1;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs change just after the falling edge; outputs are sampled 2 time units later.
  task automatic apply(input logic [2:0] r, input logic d, input logic v, input logic [1:0] t, input logic f);
    req  = r;
    rdy  = d;
    rv   = v;
    rtid = t;
    fl   = f;
    #2;
    predict();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] r;
    logic       d, v;
    logic [1:0] t;
    logic       f;
    logic [2:0] eg;
    int         et, eo, es, efd, co, eow;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] r, input logic d, input logic v, input logic [1:0] t,
                              input logic f, input logic [2:0] eg, input int et, input int eo,
                              input int es, input int efd, input int co, input int eow);
    vec_t x;
    x.r = r;  x.d = d;  x.v = v;  x.t = t;  x.f = f;
    x.eg = eg; x.et = et; x.eo = eo; x.es = es; x.efd = efd; x.co = co; x.eow = eow;
    return x;
  endfunction

  vec_t tbl[22];

  initial begin
    //             req   rdy   rv    tid   fl  |  gnt  tid out spur fd chk_own own
    tbl[0]  = mk(3'b111, 1'b1, 1'b0, 2'd0, 1'b0, 3'b001, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(3'b111, 1'b1, 1'b0, 2'd0, 1'b0, 3'b010, 1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(3'b111, 1'b1, 1'b0, 2'd0, 1'b0, 3'b100, 2, 2, 0, 0, 0, 0);
    tbl[3]  = mk(3'b001, 1'b1, 1'b0, 2'd0, 1'b0, 3'b001, 3, 3, 0, 0, 0, 0);
    tbl[4]  = mk(3'b001, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 0, 4, 0, 0, 0, 0);
    tbl[5]  = mk(3'b001, 1'b1, 1'b1, 2'd2, 1'b0, 3'b000, 0, 4, 0, 0, 1, 2);
    tbl[6]  = mk(3'b001, 1'b1, 1'b0, 2'd0, 1'b0, 3'b001, 2, 3, 0, 0, 0, 0);
    tbl[7]  = mk(3'b000, 1'b1, 1'b1, 2'd0, 1'b0, 3'b000, 0, 4, 0, 0, 1, 0);
    tbl[8]  = mk(3'b000, 1'b1, 1'b1, 2'd1, 1'b0, 3'b000, 0, 3, 0, 0, 1, 1);
    tbl[9]  = mk(3'b010, 1'b1, 1'b1, 2'd3, 1'b0, 3'b010, 0, 2, 0, 0, 1, 0);
    tbl[10] = mk(3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 0, 2, 0, 0, 0, 0);
    tbl[11] = mk(3'b111, 1'b1, 1'b0, 2'd0, 1'b1, 3'b000, 0, 2, 0, 0, 0, 0);
    tbl[12] = mk(3'b111, 1'b1, 1'b0, 2'd0, 1'b1, 3'b000, 0, 2, 0, 0, 0, 0);
    tbl[13] = mk(3'b111, 1'b1, 1'b1, 2'd0, 1'b0, 3'b000, 0, 2, 0, 0, 1, 1);
    tbl[14] = mk(3'b111, 1'b1, 1'b1, 2'd2, 1'b0, 3'b000, 0, 1, 0, 0, 1, 0);
    tbl[15] = mk(3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 0, 0, 0, 1, 0, 0);
    tbl[16] = mk(3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(3'b000, 1'b1, 1'b1, 2'd3, 1'b0, 3'b000, 0, 0, 1, 0, 0, 0);
    tbl[18] = mk(3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk(3'b000, 1'b1, 1'b0, 2'd0, 1'b1, 3'b000, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(3'b111, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 0, 0, 0, 1, 0, 0);
    tbl[21] = mk(3'b111, 1'b1, 1'b0, 2'd0, 1'b0, 3'b100, 0, 0, 0, 0, 0, 0);

    model_reset();
    @(negedge clk);
    #2;
    chk("reset gnt", int'(gnt), 0);
    chk("reset outstanding", int'(outst), 0);
    chk("reset flush_done", int'(fd), 0);
    chk("reset spurious", int'(spur), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].r, tbl[i].d, tbl[i].v, tbl[i].t, tbl[i].f);
      chk($sformatf("vec%0d gnt", i), int'(gnt), int'(tbl[i].eg));
      if (tbl[i].eg != 3'b000) chk($sformatf("vec%0d tid", i), int'(tid), tbl[i].et);
      chk($sformatf("vec%0d outstanding", i), int'(outst), tbl[i].eo);
      chk($sformatf("vec%0d spurious", i), int'(spur), tbl[i].es);
      chk($sformatf("vec%0d flush_done", i), int'(fd), tbl[i].efd);
      if (tbl[i].co != 0) chk($sformatf("vec%0d owner", i), int'(owner), tbl[i].eow);
      advance();
    end

    // Reset in the middle of three in-flight transactions (TIDs 0,1,2).
    apply(3'b111, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("pre-reset gnt a", int'(gnt), 1);
    chk("pre-reset tid a", int'(tid), 1);
    advance();
    apply(3'b111, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("pre-reset gnt b", int'(gnt), 2);
    chk("pre-reset tid b", int'(tid), 2);
    advance();
    apply(3'b000, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("pre-reset outstanding", int'(outst), 3);
    req  = 3'b111;
    rv   = 1'b1;
    rtid = 2'd1;
    rst_n = 1'b0;
    #1;
    chk("in-reset gnt", int'(gnt), 0);
    chk("in-reset outstanding", int'(outst), 0);
    chk("in-reset spurious", int'(spur), 0);
    chk("in-reset flush_done", int'(fd), 0);
    @(posedge clk);
    #2;
    chk("in-reset gnt after edge", int'(gnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply(3'b001, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("post-reset gnt", int'(gnt), 1);
    chk("post-reset tid", int'(tid), 0);
    advance();
    apply(3'b000, 1'b1, 1'b1, 2'd1, 1'b0);
    chk("post-reset stale rsp spurious", int'(spur), 1);
    chk("post-reset outstanding", int'(outst), 1);
    advance();

    for (int i = 0; i < 600; i++) begin
      logic [2:0] r;
      logic [1:0] t;
      logic       v;
      r = 3'($urandom_range(0, 7));
      t = 2'($urandom_range(0, 3));
      v = ($urandom_range(0, 9) < 4);
      if (v && $urandom_range(0, 9) < 7) begin
        for (int k = 0; k < NumTid; k++) if (m_busy[(int'(t) + k) % NumTid] == 1) begin
          t = 2'((int'(t) + k) % NumTid);
          break;
        end
      end
      apply(r, ($urandom_range(0, 3) != 0), v, t, ($urandom_range(0, 15) == 0));
      chk($sformatf("rand%0d gnt", i), int'(gnt), p_gnt);
      if (p_gnt != 0) chk($sformatf("rand%0d tid", i), int'(tid), p_tid);
      chk($sformatf("rand%0d outstanding", i), int'(outst), p_out);
      chk($sformatf("rand%0d spurious", i), int'(spur), p_spur);
      chk($sformatf("rand%0d flush_done", i), int'(fd), p_fd);
      if (rv && p_spur == 0) chk($sformatf("rand%0d owner", i), int'(owner), p_owner);
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
